// File: rtl/nfifo_mc.sv
// Multi-channel FIFO: CHANNELS queues of DEPTH words behind one shared write port and one read port.
// Define NFIFO_MC_ERR_EN to add sticky per-channel overflow/underflow outputs (ovf_o, udf_o).
module nfifo_mc #(
   parameter int unsigned WIDTH     = 32,
   parameter int unsigned CHANNELS  = 4,
   parameter int unsigned DEPTH     = 8,
   parameter int unsigned AFULL_THR = 6,
   localparam int unsigned VW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
   localparam int unsigned CW       = $clog2(DEPTH) + 1
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   write_i,
   input  logic [VW-1:0]          wr_vc_i,
   input  logic [WIDTH-1:0]       data_i,
   input  logic                   read_i,
   input  logic [VW-1:0]          rd_vc_i,
   output logic [WIDTH-1:0]       data_o,
   output logic                   valid_o,
   output logic [CHANNELS-1:0]    empty_o,
   output logic [CHANNELS-1:0]    full_o,
   output logic [CHANNELS-1:0]    afull_o,
   output logic [CHANNELS*CW-1:0] cnt_o
`ifdef NFIFO_MC_ERR_EN
   ,
   output logic [CHANNELS-1:0]    ovf_o,
   output logic [CHANNELS-1:0]    udf_o
`endif
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned MW = $clog2(CHANNELS * DEPTH);

   logic [WIDTH-1:0]    r_mem  [CHANNELS*DEPTH];
   logic [CW-1:0]       r_wptr [CHANNELS];
   logic [CW-1:0]       r_rptr [CHANNELS];
   logic [CW-1:0]       r_cnt  [CHANNELS];

   logic                w_wr_ok, w_rd_ok;
   logic                w_wr_acc, w_rd_acc;
   logic [MW-1:0]       w_waddr, w_raddr;
   logic [CHANNELS-1:0] w_wr_ch, w_rd_ch;
   logic [CHANNELS-1:0] w_empty, w_full, w_afull;

   assign w_wr_ok  = (32'(wr_vc_i) < CHANNELS);
   assign w_rd_ok  = (32'(rd_vc_i) < CHANNELS);
   assign w_rd_acc = read_i & w_rd_ok & ~w_empty[rd_vc_i];
   // A full channel still takes a write when it is popped on the same edge.
   assign w_wr_acc = write_i & w_wr_ok &
                     (~w_full[wr_vc_i] | (w_rd_acc & (rd_vc_i == wr_vc_i)));

   assign w_waddr = MW'({wr_vc_i, r_wptr[wr_vc_i][AW-1:0]});
   assign w_raddr = MW'({rd_vc_i, r_rptr[rd_vc_i][AW-1:0]});

   always_ff @(posedge clk_i) begin
      if (w_wr_acc) r_mem[w_waddr] <= data_i;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_o  <= '0;
         valid_o <= 1'b0;
      end else begin
         valid_o <= w_rd_acc;
         if (w_rd_acc) data_o <= r_mem[w_raddr];
      end
   end

   for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
      assign w_wr_ch[c] = w_wr_acc & (wr_vc_i == VW'(c));
      assign w_rd_ch[c] = w_rd_acc & (rd_vc_i == VW'(c));

      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            r_wptr[c] <= '0;
            r_rptr[c] <= '0;
            r_cnt[c]  <= '0;
         end else begin
            if (w_wr_ch[c]) r_wptr[c] <= r_wptr[c] + CW'(1);
            if (w_rd_ch[c]) r_rptr[c] <= r_rptr[c] + CW'(1);
            if (w_wr_ch[c] != w_rd_ch[c])
               r_cnt[c] <= w_wr_ch[c] ? r_cnt[c] + CW'(1) : r_cnt[c] - CW'(1);
         end
      end

      assign w_empty[c]            = (r_cnt[c] == '0);
      assign w_full[c]             = (r_cnt[c] == CW'(DEPTH));
      assign w_afull[c]            = (r_cnt[c] >= CW'(AFULL_THR));
      assign cnt_o[c*CW +: CW]     = r_cnt[c];
   end

   assign empty_o = w_empty;
   assign full_o  = w_full;
   assign afull_o = w_afull;

`ifdef NFIFO_MC_ERR_EN
   logic [CHANNELS-1:0] w_ovf_set, w_udf_set;
   logic [CHANNELS-1:0] r_ovf, r_udf;

   for (genvar c = 0; c < CHANNELS; c++) begin : g_err
      assign w_ovf_set[c] = write_i & (wr_vc_i == VW'(c)) & ~w_wr_acc;
      assign w_udf_set[c] = read_i & (rd_vc_i == VW'(c)) & ~w_rd_acc;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_ovf <= '0;
         r_udf <= '0;
      end else begin
         r_ovf <= r_ovf | w_ovf_set;
         r_udf <= r_udf | w_udf_set;
      end
   end

   assign ovf_o = r_ovf;
   assign udf_o = r_udf;
`endif

endmodule

// File: tb/tb_nfifo_mc.sv
// Scoreboard bench for nfifo_mc: reads push expected words, a negedge monitor pops on valid_o.
module tb_nfifo_mc;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        write_i, read_i;
   logic [1:0]  wr_vc_i, rd_vc_i;
   logic [31:0] data_i, data_o;
   logic        valid_o;
   logic [3:0]  empty_o, full_o, afull_o;
   logic [15:0] cnt_o;
`ifdef NFIFO_MC_ERR_EN
   logic [3:0]  ovf_o, udf_o;
`endif

   int          n_tests = 0;
   int          n_fail  = 0;
   logic [31:0] sb [$];

   always #5 clk_i = ~clk_i;

   nfifo_mc #(.WIDTH(32), .CHANNELS(4), .DEPTH(8), .AFULL_THR(6)) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .write_i (write_i),
      .wr_vc_i (wr_vc_i),
      .data_i  (data_i),
      .read_i  (read_i),
      .rd_vc_i (rd_vc_i),
      .data_o  (data_o),
      .valid_o (valid_o),
      .empty_o (empty_o),
      .full_o  (full_o),
      .afull_o (afull_o),
      .cnt_o   (cnt_o)
`ifdef NFIFO_MC_ERR_EN
      ,
      .ovf_o   (ovf_o),
      .udf_o   (udf_o)
`endif
   );

   // Monitor: every valid_o must match the oldest outstanding expected word.
   always @(negedge clk_i) begin
      logic [31:0] exp_w;
      if (valid_o === 1'b1) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL sb_unexpected: data_o=%h valid with no word expected", data_o);
         end else begin
            exp_w = sb.pop_front();
            if (data_o !== exp_w) begin
               n_fail++;
               $display("FAIL sb_data: data_o=%h expected %h", data_o, exp_w);
            end
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      n_tests++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp_v);
      end
   endtask

   // One clock of stimulus; returns 1 time unit after the edge.
   task automatic op(input logic w, input logic [1:0] wv, input logic [31:0] wd,
                     input logic r, input logic [1:0] rv);
      write_i = w; wr_vc_i = wv; data_i = wd;
      read_i  = r; rd_vc_i = rv;
      @(posedge clk_i);
      #1;
      write_i = 1'b0; read_i = 1'b0;
   endtask

   task automatic rd_exp(input logic [1:0] rv, input logic [31:0] exp_w);
      sb.push_back(exp_w);
      op(1'b0, 2'd0, 32'h0, 1'b1, rv);
   endtask

   function automatic logic [3:0] cnt_of(input int c);
      return cnt_o[c*4 +: 4];
   endfunction

   initial begin
      rst_i = 1'b1;
      write_i = 1'b0; read_i = 1'b0; wr_vc_i = '0; rd_vc_i = '0; data_i = '0;
      #3;
      chk("rst_empty", 64'(empty_o), 64'hF);
      chk("rst_full",  64'(full_o),  64'h0);
      chk("rst_afull", 64'(afull_o), 64'h0);
      chk("rst_cnt",   64'(cnt_o),   64'h0);
      chk("rst_valid", 64'(valid_o), 64'h0);
      chk("rst_data",  64'(data_o),  64'h0);
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i); #1;

      // Single channel fill/drain on vc2
      for (int i = 0; i < 8; i++) begin
         op(1'b1, 2'd2, 32'(i), 1'b0, 2'd0);
         chk("fill_cnt",   64'(cnt_of(2)),  64'(i + 1));
         chk("fill_afull", 64'(afull_o[2]), 64'(i + 1 >= 6));
      end
      chk("fill_full",  64'(full_o),  64'h4);
      chk("fill_empty", 64'(empty_o), 64'hB);
      for (int i = 0; i < 8; i++) rd_exp(2'd2, 32'(i));
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
      chk("drain_empty", 64'(empty_o), 64'hF);
      chk("drain_valid", 64'(valid_o), 64'h0);

      // Interleaved channels
      op(1'b1, 2'd0, 32'hA0, 1'b0, 2'd0);
      op(1'b1, 2'd1, 32'hB0, 1'b0, 2'd0);
      op(1'b1, 2'd0, 32'hA1, 1'b0, 2'd0);
      chk("intl_cnt", 64'(cnt_o), 64'h0012);
      rd_exp(2'd1, 32'hB0);
      rd_exp(2'd0, 32'hA0);
      rd_exp(2'd0, 32'hA1);
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
      chk("intl_cnt0", 64'(cnt_o), 64'h0);

      // Full pass-through on vc3
      for (int i = 0; i < 8; i++) op(1'b1, 2'd3, 32'h30 + 32'(i), 1'b0, 2'd0);
      chk("pt_full", 64'(full_o), 64'h8);
      sb.push_back(32'h30);
      op(1'b1, 2'd3, 32'hFF, 1'b1, 2'd3);
      chk("pt_cnt",  64'(cnt_of(3)), 64'd8);
      chk("pt_full2", 64'(full_o),   64'h8);
      for (int i = 1; i < 8; i++) rd_exp(2'd3, 32'h30 + 32'(i));
      rd_exp(2'd3, 32'hFF);
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
      chk("pt_empty", 64'(empty_o), 64'hF);

      // Empty channel write+read: no bypass
      op(1'b1, 2'd1, 32'h5A, 1'b1, 2'd1);
      chk("ewr_valid", 64'(valid_o),   64'h0);
      chk("ewr_cnt",   64'(cnt_of(1)), 64'd1);
      rd_exp(2'd1, 32'h5A);
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);

      // Rejects: write to full vc0, read of empty vc2
      for (int i = 0; i < 8; i++) op(1'b1, 2'd0, 32'h40 + 32'(i), 1'b0, 2'd0);
      op(1'b1, 2'd0, 32'h99, 1'b0, 2'd0);
      chk("rej_wcnt", 64'(cnt_o), 64'h0008);
      op(1'b0, 2'd0, 32'h0, 1'b1, 2'd2);
      chk("rej_rvalid", 64'(valid_o), 64'h0);
      chk("rej_rcnt",   64'(cnt_o),   64'h0008);
`ifdef NFIFO_MC_ERR_EN
      chk("rej_ovf", 64'(ovf_o), 64'h1);
      chk("rej_udf", 64'(udf_o), 64'h4);
`endif
      for (int i = 0; i < 8; i++) rd_exp(2'd0, 32'h40 + 32'(i));
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
      chk("rej_empty", 64'(empty_o), 64'hF);
`ifdef NFIFO_MC_ERR_EN
      chk("rej_ovf_sticky", 64'(ovf_o), 64'h1);
      chk("rej_udf_sticky", 64'(udf_o), 64'h4);
`endif

      // Async reset mid-cycle with 5 words queued and valid_o high
      for (int i = 0; i < 5; i++) op(1'b1, 2'd1, 32'h60 + 32'(i), 1'b0, 2'd0);
      op(1'b0, 2'd0, 32'h0, 1'b1, 2'd1);
      chk("ar_pre_valid", 64'(valid_o),   64'h1);
      chk("ar_pre_data",  64'(data_o),    64'h60);
      chk("ar_pre_cnt",   64'(cnt_of(1)), 64'd4);
      #1 rst_i = 1'b1;
      #1;
      chk("ar_empty", 64'(empty_o), 64'hF);
      chk("ar_valid", 64'(valid_o), 64'h0);
      chk("ar_cnt",   64'(cnt_o),   64'h0);
      chk("ar_data",  64'(data_o),  64'h0);
      chk("ar_full",  64'(full_o),  64'h0);
`ifdef NFIFO_MC_ERR_EN
      chk("ar_ovf", 64'(ovf_o), 64'h0);
      chk("ar_udf", 64'(udf_o), 64'h0);
`endif
      @(negedge clk_i) rst_i = 1'b0;
      @(posedge clk_i); #1;
      op(1'b1, 2'd1, 32'h77, 1'b0, 2'd0);
      rd_exp(2'd1, 32'h77);
      op(1'b0, 2'd0, 32'h0, 1'b0, 2'd0);
      chk("post_empty", 64'(empty_o), 64'hF);

      @(negedge clk_i);
      #1;
      chk("sb_drained", 64'(sb.size()), 64'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
